// File: rtl/encode_4_2_irq.sv
// Registered 4-to-2 priority encoder with request capture and a valid/ready
// output handshake. Requests are latched into a pending register, the
// winner is offered as a 2-bit code, and its pending bit is cleared only
// when the consumer accepts it.
module encode_4_2_irq #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [3:0] I,
    input  logic       Rdy,
    output logic [1:0] Y,
    output logic       V,
    output logic [3:0] Pend,
    output logic       Ovf
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [1:0] y_q, y_d;
    logic       ovf_q, ovf_d;

    logic [3:0] set_vec;
    logic [3:0] clr_vec;
    logic [1:0] winner;

    // Picks the winning pending index; the order depends on LOW_FIRST.
    function automatic logic [1:0] prio_encode(input logic [3:0] req);
        logic [1:0] idx;
        idx = 2'd0;
        if (LOW_FIRST) begin
            for (int k = 3; k >= 0; k--) begin
                if (req[k]) idx = 2'(k);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (req[k]) idx = 2'(k);
            end
        end
        return idx;
    endfunction

    // Capture, accept-clear and overflow: a new request on a bit being
    // cleared in the same cycle wins, so that event is not lost.
    always_comb begin
        set_vec = En ? I : 4'b0000;
        clr_vec = 4'b0000;
        if (state_q == OFFER && Rdy) begin
            clr_vec[y_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
        ovf_d  = ovf_q | (|(set_vec & pend_q & ~clr_vec));
    end

    // Offer state machine: IDLE loads the winner of the current pending
    // set, OFFER holds the code until accepted (no preemption).
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        winner  = prio_encode(pend_q);
        case (state_q)
            IDLE: begin
                y_d = 2'd0;
                if (pend_q != 4'b0000) begin
                    y_d     = winner;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (Rdy) begin
                    y_d     = 2'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                y_d     = 2'd0;
                state_d = IDLE;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            y_q     <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Y    = y_q;
    assign V    = (state_q == OFFER);
    assign Pend = pend_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_encode_4_2_irq.sv
// Directed self-checking bench for encode_4_2_irq, with one instance per
// priority order sharing the same inputs.
module tb_encode_4_2_irq;

    logic       clk;
    logic       rst;
    logic       En;
    logic [3:0] I;
    logic       Rdy;

    logic [1:0] y0, y1;
    logic       v0, v1;
    logic [3:0] pend0, pend1;
    logic       ovf0, ovf1;

    int testCount;
    int failCount;

    encode_4_2_irq #(.LOW_FIRST(1'b0)) dutHigh (
        .clk(clk), .rst(rst), .En(En), .I(I), .Rdy(Rdy),
        .Y(y0), .V(v0), .Pend(pend0), .Ovf(ovf0)
    );

    encode_4_2_irq #(.LOW_FIRST(1'b1)) dutLow (
        .clk(clk), .rst(rst), .En(En), .I(I), .Rdy(Rdy),
        .Y(y1), .V(v1), .Pend(pend1), .Ovf(ovf1)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic e,
                                 input logic [3:0] req, input logic rd);
        rst = r;
        En  = e;
        I   = req;
        Rdy = rd;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Directed sequence; each tick enters the next cycle.
    initial begin
        testCount = 0;
        failCount = 0;

        applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0);
        checkOutput("reset_pend", pend0, 4'b0000);
        checkOutput("reset_y", {2'b00, y0}, 4'd0);
        checkOutput("reset_v", {3'b000, v0}, 4'd0);
        checkOutput("reset_ovf", {3'b000, ovf0}, 4'd0);

        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
        checkOutput("single_c1_pend", pend0, 4'b0100);
        checkOutput("single_c1_v", {3'b000, v0}, 4'd0);
        tick();
        checkOutput("single_c2_v", {3'b000, v0}, 4'd1);
        checkOutput("single_c2_y", {2'b00, y0}, 4'd2);
        tick();
        checkOutput("single_c3_v", {3'b000, v0}, 4'd0);
        checkOutput("single_c3_y", {2'b00, y0}, 4'd0);
        checkOutput("single_c3_pend", pend0, 4'b0000);

        applyStimulus(1'b0, 1'b1, 4'b1011, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
        checkOutput("prio_c1_pend", pend0, 4'b1011);
        tick();
        checkOutput("prio_c2_v", {3'b000, v0}, 4'd1);
        checkOutput("prio_c2_yhigh", {2'b00, y0}, 4'd3);
        checkOutput("prio_c2_ylow", {2'b00, y1}, 4'd0);
        tick();
        checkOutput("prio_c3_v", {3'b000, v0}, 4'd0);
        checkOutput("prio_c3_pendhigh", pend0, 4'b0011);
        checkOutput("prio_c3_pendlow", pend1, 4'b1010);
        tick();
        checkOutput("prio_c4_yhigh", {2'b00, y0}, 4'd1);
        checkOutput("prio_c4_ylow", {2'b00, y1}, 4'd1);
        tick();
        checkOutput("prio_c5_v", {3'b000, v0}, 4'd0);
        tick();
        checkOutput("prio_c6_v", {3'b000, v1}, 4'd1);
        checkOutput("prio_c6_yhigh", {2'b00, y0}, 4'd0);
        checkOutput("prio_c6_ylow", {2'b00, y1}, 4'd3);
        tick();
        checkOutput("prio_c7_pend", pend0, 4'b0000);
        checkOutput("prio_c7_v", {3'b000, v1}, 4'd0);

        applyStimulus(1'b0, 1'b1, 4'b0001, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        checkOutput("bp_c2_v", {3'b000, v0}, 4'd1);
        checkOutput("bp_c2_y", {2'b00, y0}, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'b1000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
        checkOutput("bp_c3_v", {3'b000, v0}, 4'd1);
        checkOutput("bp_c3_y", {2'b00, y0}, 4'd0);
        checkOutput("bp_c3_pend", pend0, 4'b1001);
        checkOutput("bp_c3_ovf", {3'b000, ovf0}, 4'd0);
        tick();
        checkOutput("bp_c4_v", {3'b000, v0}, 4'd0);
        checkOutput("bp_c4_pend", pend0, 4'b1000);
        tick();
        checkOutput("bp_c5_v", {3'b000, v0}, 4'd1);
        checkOutput("bp_c5_y", {2'b00, y0}, 4'd3);
        tick();
        checkOutput("bp_c6_pend", pend0, 4'b0000);

        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        checkOutput("sw_offer_y", {2'b00, y0}, 4'd1);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        checkOutput("sw_accept_v", {3'b000, v0}, 4'd0);
        checkOutput("sw_accept_pend", pend0, 4'b0010);
        checkOutput("sw_accept_ovf", {3'b000, ovf0}, 4'd0);
        tick();
        checkOutput("sw_reoffer_v", {3'b000, v0}, 4'd1);
        checkOutput("sw_reoffer_y", {2'b00, y0}, 4'd1);
        applyStimulus(1'b0, 1'b1, 4'b0010, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        checkOutput("ovf_set", {3'b000, ovf0}, 4'd1);
        tick();
        checkOutput("ovf_sticky", {3'b000, ovf0}, 4'd1);
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
        tick();
        checkOutput("ovf_after_xfer_pend", pend0, 4'b0000);
        checkOutput("ovf_after_xfer", {3'b000, ovf0}, 4'd1);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        checkOutput("ovf_cleared", {3'b000, ovf0}, 4'd0);

        applyStimulus(1'b0, 1'b0, 4'b1111, 1'b0);
        repeat (5) tick();
        checkOutput("en_gate_pend", pend0, 4'b0000);
        checkOutput("en_gate_v", {3'b000, v0}, 4'd0);
        applyStimulus(1'b0, 1'b1, 4'b0100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
        checkOutput("en_pre_pend", pend0, 4'b0100);
        tick();
        checkOutput("en_off_v", {3'b000, v0}, 4'd1);
        checkOutput("en_off_y", {2'b00, y0}, 4'd2);
        tick();
        checkOutput("en_off_pend", pend0, 4'b0000);
        checkOutput("en_off_done_v", {3'b000, v0}, 4'd0);

        applyStimulus(1'b0, 1'b1, 4'b1100, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        tick();
        checkOutput("mr_offer_v", {3'b000, v0}, 4'd1);
        checkOutput("mr_offer_pend", pend0, 4'b1100);
        applyStimulus(1'b1, 1'b1, 4'b0001, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 4'b0000, 1'b0);
        checkOutput("mr_v", {3'b000, v0}, 4'd0);
        checkOutput("mr_y", {2'b00, y0}, 4'd0);
        checkOutput("mr_pend", pend0, 4'b0000);
        checkOutput("mr_ovf", {3'b000, ovf0}, 4'd0);
        tick();
        checkOutput("mr_after_v", {3'b000, v0}, 4'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/encode_4_2_irq.md
# encode_4_2_irq

Registered 4-to-2 priority encoder with request capture and a valid/ready output handshake. It is the encode-side counterpart of the 2-to-4 decoder. It latches one-hot or multi-hot request pulses into a pending register and presents the index of the winning pending request as a 2-bit code. It clears that request only when the consumer accepts it. It sits between event sources (interrupt lines, strobes) and a consumer that later drives a 2-to-4 decoder with the code.

## Interface
- `LOW_FIRST`, default 0: priority order. 0 = highest index wins (I[3] over I[0]); 1 = lowest index wins.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `En`  in  1  capture enable; when 0, I is ignored (pending requests are still served).
- `I`  in  4  request inputs, sampled each clock; any number may be high.
- `Rdy`  in  1  consumer ready; the transfer occurs on a cycle with V=1 and Rdy=1.
- `Y`  out  2  encoded index of the request being offered; registered.
- `V`  out  1  Y is valid; registered.
- `Pend`  out  4  pending-request register (Pend[k]=1 means request k is captured but not yet accepted).
- `Ovf`  out  1  sticky flag: a request was lost because its bit was already pending.

## Operation
- Reset (`rst`=1 at an edge): Pend=0, Y=0, V=0, Ovf=0, state=IDLE.
  - `rst` overrides everything, including I and Rdy in the same cycle.
- Capture: set = En ? I : 4'b0000; clr = one-hot(Y) when V&Rdy, else 0.
  - Pend_next = (Pend & ~clr) | set.
  - When set and clr hit the same bit, set wins and the bit stays pending, so the new event is kept.
- Overflow: Ovf_next = Ovf | |(set & Pend & ~clr).
  - Ovf is sticky until reset.
- State machine (2 states):
  - IDLE: V=0. If Pend≠0, load Y = priority-encode(Pend) per `LOW_FIRST`, set V=1, and go to OFFER. If Pend=0, stay in IDLE with Y=0.
  - OFFER: V=1 and Y held constant. No preemption: a higher-priority arrival does not change Y.
  - OFFER with Rdy=0: stay in OFFER.
  - OFFER with Rdy=1: transfer. Next edge: V=0, Y=0, state=IDLE, and bit Y of Pend is cleared (subject to the set-wins rule).
- Y is 0 whenever V=0.
- Encoding is the exact inverse of the 2-to-4 decoder: Pend one-hot 0001→00, 0010→01, 0100→10, 1000→11.

## Timing
- Request-to-valid latency (from IDLE): 2 cycles.
  - I[k] is high in cycle 0 and captured at edge 0, so Pend[k]=1 in cycle 1.
  - IDLE evaluates Pend in cycle 1, so V=1 and Y=k in cycle 2.
- Transfer: the edge ending a cycle with V=1 and Rdy=1. V drops in the following cycle.
- Throughput: at most 1 transfer per 2 cycles, because there is a mandatory single IDLE bubble after each transfer.
- Re-evaluation after a transfer uses the already-cleared Pend: remaining bits are offered 1 cycle after V drops.
- Rdy while V=0 has no effect. Rdy may be held high permanently.
- Rdy is not required to depend combinationally on V; no combinational path exists from any input to any output.
- Reset mid-offer: V=0 and Pend=0 at the next edge, and the offered request is discarded without a transfer.

## Test plan
- Reset then single request: pulse I=4'b0100 with En=1 for 1 cycle, Rdy=1 → Pend=0100 in cycle 1; Y=2'b10, V=1 in cycle 2; V=0, Pend=0 in cycle 3.
- Priority and ordering, `LOW_FIRST`=0: pulse I=4'b1011 with Rdy=1 → transfers Y=11, 01, 00 in that order, each V pulse 1 cycle wide, 2 cycles apart. With `LOW_FIRST`=1 the order is 00, 01, 11.
- Backpressure and no preemption: I=0001, Rdy=0 → V=1, Y=00. Then pulse I=1000 → Y stays 00 and Pend=1001. Raise Rdy → transfer 00, then V=1, Y=11 two cycles later.
- Set-wins and overflow: in OFFER with Y=01, pulse I=0010 in the accept cycle → Pend[1] stays 1, Ovf stays 0, and 01 is offered again. Separately, pulse I=0010 while Pend[1]=1 with no accept → Ovf=1 and stays 1 until `rst`.
- Enable gating: En=0 with I=1111 for 5 cycles → Pend=0, V=0. Then with pre-existing Pend=0100 and En=0, Rdy=1 → 10 is still transferred.
- Mid-operation reset: in OFFER with Pend=1100, assert `rst` for 1 cycle together with I=0001 and Rdy=1 → next cycle V=0, Y=0, Pend=0, Ovf=0, and no transfer is counted.
